// File: rtl/tcp_rx_win_pkg.sv
// Shared types and sizing helpers for the TCP receive window / ACK controller.
package tcp_rx_win_pkg;

  // Default flow geometry; the descriptor structs are sized to it.
  localparam int DEF_PTR_W = 12;
  localparam int DEF_WIN_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PEND = 2'd1,
    ST_SEND = 2'd2
  } ack_state_e;

  typedef struct packed {
    logic [DEF_PTR_W:0] start_ptr;
    logic [DEF_PTR_W:0] len;
  } seg_desc_t;

  typedef struct packed {
    logic [DEF_PTR_W:0]   ptr;
    logic [DEF_WIN_W-1:0] win;
  } ack_req_t;

  function automatic longint buf_bytes(input int ptr_w);
    return longint'(1) << ptr_w;
  endfunction

endpackage

// File: rtl/rx_win_sws_calc.sv
// Free-space, raw window and silly-window-avoidance update decision for one flow.
module rx_win_sws_calc
  import tcp_rx_win_pkg::*;
#(
  parameter int PTR_W        = 12,
  parameter int WIN_SIZE_W   = 16,
  parameter int MAX_SEG_SIZE = 1024
) (
  input  logic [PTR_W:0]      rcv_nxt_ptr,
  input  logic [PTR_W:0]      app_rd_ptr,
  input  logic [WIN_SIZE_W-1:0] adv_win,
  output logic [PTR_W:0]      free,
  output logic [WIN_SIZE_W-1:0] raw_win,
  output logic                win_upd
);

  localparam int CW = ((PTR_W + 1 > WIN_SIZE_W) ? PTR_W + 1 : WIN_SIZE_W) + 1;
  localparam logic [PTR_W:0] BUF_PTR = (PTR_W + 1)'(buf_bytes(PTR_W));
  localparam logic [CW-1:0]  WIN_MAX = CW'((longint'(1) << WIN_SIZE_W) - longint'(1));
  localparam logic [CW-1:0]  MSS_C   = CW'(MAX_SEG_SIZE);

  logic [PTR_W:0] used_s;
  logic [CW-1:0]  free_ext_s;
  logic [CW-1:0]  raw_ext_s;
  logic [CW-1:0]  adv_ext_s;

  // Only grow the window in MSS-sized steps so the right edge never creeps.
  always_comb begin
    used_s     = rcv_nxt_ptr - app_rd_ptr;
    free       = BUF_PTR - used_s;
    free_ext_s = CW'(free);
    adv_ext_s  = CW'(adv_win);
    if (free_ext_s < WIN_MAX) begin
      raw_ext_s = free_ext_s;
    end else begin
      raw_ext_s = WIN_MAX;
    end
    raw_win = WIN_SIZE_W'(raw_ext_s);
    win_upd = ((raw_ext_s >= adv_ext_s) && ((raw_ext_s - adv_ext_s) >= MSS_C)) ||
              ((adv_ext_s == {CW{1'b0}}) && (raw_ext_s >= MSS_C));
  end

endmodule

// File: rtl/tcp_rx_win_ack_ctrl.sv
// RX segment acceptance, advertised window and ACK request control for one flow.
// Delayed-ACK (PEND state, segment threshold, timer) is built with TCP_RX_DELAYED_ACK_EN.
module tcp_rx_win_ack_ctrl
  import tcp_rx_win_pkg::*;
#(
  parameter int PTR_W              = 12,
  parameter int WIN_SIZE_W         = 16,
  parameter int MAX_SEG_SIZE       = 1024,
  parameter int ACK_SEG_THRESH     = 2,
  parameter int ACK_TIMEOUT_CYCLES = 2000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  init_val,
  input  logic [PTR_W:0]        init_rcv_ptr,
  input  logic                  seg_val,
  output logic                  seg_rdy,
  input  logic [PTR_W:0]        seg_start_ptr,
  input  logic [PTR_W:0]        seg_len,
  output logic                  seg_res_val,
  input  logic                  seg_res_rdy,
  output logic                  seg_res_accept,
  input  logic [PTR_W:0]        app_rd_ptr,
  output logic [PTR_W:0]        rcv_nxt_ptr,
  output logic [WIN_SIZE_W-1:0] adv_win,
  output logic                  ack_req_val,
  input  logic                  ack_req_rdy,
  output logic [PTR_W:0]        ack_req_ptr,
  output logic [WIN_SIZE_W-1:0] ack_req_win
);

  localparam longint WIN_MAX_L = (longint'(1) << WIN_SIZE_W) - longint'(1);
  localparam logic [WIN_SIZE_W-1:0] INIT_WIN =
    WIN_SIZE_W'((buf_bytes(PTR_W) < WIN_MAX_L) ? buf_bytes(PTR_W) : WIN_MAX_L);

  ack_state_e            state_r, state_nxt_s;
  logic                  pend_r;
  logic [PTR_W:0]        rcv_nxt_r, rcv_nxt_nxt_s, free_s, ack_ptr_r;
  logic [WIN_SIZE_W-1:0] adv_win_r, adv_win_nxt_s, raw_win_s, ack_win_r;
  logic                  seg_res_val_r, seg_res_accept_r;
  logic                  win_upd_s, seg_hs_s, seg_ok_s, acc_data_s, rej_s, upd_s;
  logic                  ack_evt_s, kick_s, ack_hs_s, ack_load_s;

  rx_win_sws_calc #(
    .PTR_W       (PTR_W),
    .WIN_SIZE_W  (WIN_SIZE_W),
    .MAX_SEG_SIZE(MAX_SEG_SIZE)
  ) u_sws (
    .rcv_nxt_ptr(rcv_nxt_r),
    .app_rd_ptr (app_rd_ptr),
    .adv_win    (adv_win_r),
    .free       (free_s),
    .raw_win    (raw_win_s),
    .win_upd    (win_upd_s)
  );

  assign seg_rdy  = ~seg_res_val_r | seg_res_rdy;
  assign seg_hs_s = seg_val & seg_rdy;
  assign ack_hs_s = ack_req_val & ack_req_rdy;

  // Acceptance decision and next pointer/window; an accept defers the SWS check a cycle.
  always_comb begin
    seg_ok_s   = (seg_start_ptr == rcv_nxt_r) && (seg_len <= free_s) &&
                 (32'(seg_len) <= 32'(MAX_SEG_SIZE));
    acc_data_s = seg_hs_s && seg_ok_s && (seg_len != {(PTR_W + 1){1'b0}});
    rej_s      = seg_hs_s && !seg_ok_s;
    upd_s      = win_upd_s && !acc_data_s;
    rcv_nxt_nxt_s = rcv_nxt_r;
    adv_win_nxt_s = adv_win_r;
    if (acc_data_s) begin
      rcv_nxt_nxt_s = rcv_nxt_r + seg_len;
      if (32'(seg_len) >= 32'(adv_win_r)) begin
        adv_win_nxt_s = {WIN_SIZE_W{1'b0}};
      end else begin
        adv_win_nxt_s = adv_win_r - WIN_SIZE_W'(seg_len);
      end
    end else if (upd_s) begin
      adv_win_nxt_s = raw_win_s;
    end else begin
      adv_win_nxt_s = adv_win_r;
    end
  end

`ifdef TCP_RX_DELAYED_ACK_EN
  localparam int CNT_W = $clog2(ACK_SEG_THRESH + 1);
  localparam int TMR_W = (ACK_TIMEOUT_CYCLES > 2) ? $clog2(ACK_TIMEOUT_CYCLES) : 1;

  logic [CNT_W-1:0] seg_cnt_r;
  logic [TMR_W-1:0] timer_r;
  logic             thresh_hit_s, timeout_s;

  assign ack_evt_s    = rej_s | upd_s;
  assign thresh_hit_s = acc_data_s && ((32'(seg_cnt_r) + 32'd1) >= 32'(ACK_SEG_THRESH));
  assign timeout_s    = 32'(timer_r) >= 32'(ACK_TIMEOUT_CYCLES - 1);

  // Delayed-ACK segment counter and timer, restarted on every entry into PEND.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_cnt_r <= {CNT_W{1'b0}};
      timer_r   <= {TMR_W{1'b0}};
    end else if (init_val) begin
      seg_cnt_r <= {CNT_W{1'b0}};
      timer_r   <= {TMR_W{1'b0}};
    end else if ((state_nxt_s == ST_PEND) && (state_r != ST_PEND)) begin
      seg_cnt_r <= CNT_W'(1);
      timer_r   <= {TMR_W{1'b0}};
    end else if (state_r == ST_PEND) begin
      timer_r <= timer_r + TMR_W'(1);
      if (acc_data_s) begin
        seg_cnt_r <= seg_cnt_r + CNT_W'(1);
      end
    end else begin
      seg_cnt_r <= {CNT_W{1'b0}};
      timer_r   <= {TMR_W{1'b0}};
    end
  end
`else
  assign ack_evt_s = rej_s | upd_s | acc_data_s;
`endif

  assign kick_s     = ack_evt_s | acc_data_s;
  assign ack_load_s = (state_nxt_s == ST_SEND) && ((state_r != ST_SEND) || ack_hs_s);

  // ACK FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else if (init_val) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // ACK FSM next-state decode.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (ack_evt_s) begin
          state_nxt_s = ST_SEND;
`ifdef TCP_RX_DELAYED_ACK_EN
        end else if (acc_data_s) begin
          state_nxt_s = (ACK_SEG_THRESH <= 1) ? ST_SEND : ST_PEND;
`endif
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
`ifdef TCP_RX_DELAYED_ACK_EN
      ST_PEND: begin
        if (ack_evt_s || thresh_hit_s || timeout_s) begin
          state_nxt_s = ST_SEND;
        end else begin
          state_nxt_s = ST_PEND;
        end
      end
`endif
      ST_SEND: begin
        if (!ack_hs_s) begin
          state_nxt_s = ST_SEND;
        end else if (pend_r || kick_s) begin
`ifdef TCP_RX_DELAYED_ACK_EN
          state_nxt_s = ST_PEND;
`else
          state_nxt_s = ST_SEND;
`endif
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // ACK FSM outputs.
  always_comb begin
    ack_req_val = (state_r == ST_SEND);
    ack_req_ptr = ack_ptr_r;
    ack_req_win = ack_win_r;
  end

  // Flow state, segment result and captured ACK payload.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rcv_nxt_r        <= {(PTR_W + 1){1'b0}};
      adv_win_r        <= {WIN_SIZE_W{1'b0}};
      seg_res_val_r    <= 1'b0;
      seg_res_accept_r <= 1'b0;
      ack_ptr_r        <= {(PTR_W + 1){1'b0}};
      ack_win_r        <= {WIN_SIZE_W{1'b0}};
      pend_r           <= 1'b0;
    end else if (init_val) begin
      rcv_nxt_r        <= init_rcv_ptr;
      adv_win_r        <= INIT_WIN;
      seg_res_val_r    <= 1'b0;
      seg_res_accept_r <= 1'b0;
      ack_ptr_r        <= {(PTR_W + 1){1'b0}};
      ack_win_r        <= {WIN_SIZE_W{1'b0}};
      pend_r           <= 1'b0;
    end else begin
      rcv_nxt_r <= rcv_nxt_nxt_s;
      adv_win_r <= adv_win_nxt_s;
      if (seg_hs_s) begin
        seg_res_val_r    <= 1'b1;
        seg_res_accept_r <= seg_ok_s;
      end else if (seg_res_rdy) begin
        seg_res_val_r <= 1'b0;
      end
      if (ack_load_s) begin
        ack_ptr_r <= rcv_nxt_nxt_s;
        ack_win_r <= adv_win_nxt_s;
      end
      pend_r <= (state_r == ST_SEND) && !ack_hs_s && (pend_r || kick_s);
    end
  end

  assign seg_res_val    = seg_res_val_r;
  assign seg_res_accept = seg_res_accept_r;
  assign rcv_nxt_ptr    = rcv_nxt_r;
  assign adv_win        = adv_win_r;

endmodule

// File: tb/tb_tcp_rx_win_ack_ctrl.sv
// Directed self-checking bench for tcp_rx_win_ack_ctrl (default geometry).
module tb_tcp_rx_win_ack_ctrl;
  import tcp_rx_win_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        init_val = 1'b0;
  logic [12:0] init_rcv_ptr = 13'd0;
  logic        seg_val = 1'b0;
  logic        seg_rdy;
  logic [12:0] seg_start_ptr = 13'd0;
  logic [12:0] seg_len = 13'd0;
  logic        seg_res_val;
  logic        seg_res_rdy = 1'b1;
  logic        seg_res_accept;
  logic [12:0] app_rd_ptr = 13'd0;
  logic [12:0] rcv_nxt_ptr;
  logic [15:0] adv_win;
  logic        ack_req_val;
  logic        ack_req_rdy = 1'b0;
  logic [12:0] ack_req_ptr;
  logic [15:0] ack_req_win;

  int checks = 0;
  int errors = 0;
  int n_cyc;

  tcp_rx_win_ack_ctrl dut (
    .clk(clk), .rst_n(rst_n), .init_val(init_val), .init_rcv_ptr(init_rcv_ptr),
    .seg_val(seg_val), .seg_rdy(seg_rdy), .seg_start_ptr(seg_start_ptr), .seg_len(seg_len),
    .seg_res_val(seg_res_val), .seg_res_rdy(seg_res_rdy), .seg_res_accept(seg_res_accept),
    .app_rd_ptr(app_rd_ptr), .rcv_nxt_ptr(rcv_nxt_ptr), .adv_win(adv_win),
    .ack_req_val(ack_req_val), .ack_req_rdy(ack_req_rdy),
    .ack_req_ptr(ack_req_ptr), .ack_req_win(ack_req_win)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic send_seg(input seg_desc_t d, input logic exp_acc, input string tag);
    @(negedge clk);
    seg_val = 1'b1;
    seg_start_ptr = d.start_ptr;
    seg_len = d.len;
    @(posedge clk);
    #1;
    seg_val = 1'b0;
    chk({tag, "_res_val"}, 32'(seg_res_val), 32'd1);
    chk({tag, "_accept"}, 32'(seg_res_accept), 32'(exp_acc));
  endtask

  task automatic wait_ack(input ack_req_t e, input string tag);
    int n = 0;
    while (ack_req_val !== 1'b1 && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({tag, "_seen"}, 32'(ack_req_val), 32'd1);
    chk({tag, "_ptr"}, 32'(ack_req_ptr), 32'(e.ptr));
    chk({tag, "_win"}, 32'(ack_req_win), 32'(e.win));
    ack_req_rdy = 1'b1;
    @(posedge clk);
    #1;
    ack_req_rdy = 1'b0;
    chk({tag, "_done"}, 32'(ack_req_val), 32'd0);
  endtask

  task automatic quiet(input int cycles, input string tag);
    repeat (cycles) @(posedge clk);
    #1;
    chk(tag, 32'(ack_req_val), 32'd0);
  endtask

  task automatic do_init(input logic [12:0] p);
    @(negedge clk);
    rst_n = 1'b1;
    init_val = 1'b1;
    init_rcv_ptr = p;
    app_rd_ptr = p;
    @(posedge clk);
    #1;
    init_val = 1'b0;
  endtask

  initial begin
    #12;
    chk("rst_rcv_nxt", 32'(rcv_nxt_ptr), 32'd0);
    chk("rst_adv_win", 32'(adv_win), 32'd0);
    chk("rst_ack_val", 32'(ack_req_val), 32'd0);
    chk("rst_res_val", 32'(seg_res_val), 32'd0);

    do_init(13'd100);
    chk("init_rcv_nxt", 32'(rcv_nxt_ptr), 32'd100);
    chk("init_adv_win", 32'(adv_win), 32'd4096);
    chk("init_ack_val", 32'(ack_req_val), 32'd0);

    // Zero-length segment, result held while the consumer stalls
    seg_res_rdy = 1'b0;
    send_seg('{start_ptr: 13'd100, len: 13'd0}, 1'b1, "zero");
    chk("zero_rcv_nxt", 32'(rcv_nxt_ptr), 32'd100);
    @(posedge clk);
    #1;
    chk("hold_res_val", 32'(seg_res_val), 32'd1);
    chk("hold_seg_rdy", 32'(seg_rdy), 32'd0);
    seg_res_rdy = 1'b1;
    @(posedge clk);
    #1;
    chk("release_res_val", 32'(seg_res_val), 32'd0);
    quiet(5, "zero_no_ack");

    send_seg('{start_ptr: 13'd100, len: 13'd1024}, 1'b1, "seg1");
`ifdef TCP_RX_DELAYED_ACK_EN
    chk("seg1_no_ack", 32'(ack_req_val), 32'd0);
`else
    wait_ack('{ptr: 13'd1124, win: 16'd3072}, "ack_seg1");
`endif
    send_seg('{start_ptr: 13'd1124, len: 13'd1024}, 1'b1, "seg2");
    wait_ack('{ptr: 13'd2148, win: 16'd2048}, "ack_pair");
    chk("pair_rcv_nxt", 32'(rcv_nxt_ptr), 32'd2148);

    send_seg('{start_ptr: 13'd3000, len: 13'd100}, 1'b0, "ooo");
    wait_ack('{ptr: 13'd2148, win: 16'd2048}, "ack_ooo");
    chk("ooo_rcv_nxt", 32'(rcv_nxt_ptr), 32'd2148);

    send_seg('{start_ptr: 13'd2148, len: 13'd1024}, 1'b1, "fill1");
`ifndef TCP_RX_DELAYED_ACK_EN
    wait_ack('{ptr: 13'd3172, win: 16'd1024}, "ack_fill1");
`endif
    send_seg('{start_ptr: 13'd3172, len: 13'd1024}, 1'b1, "fill2");
    wait_ack('{ptr: 13'd4196, win: 16'd0}, "ack_fill2");
    chk("full_adv_win", 32'(adv_win), 32'd0);

    send_seg('{start_ptr: 13'd4196, len: 13'd1}, 1'b0, "overrun");
    wait_ack('{ptr: 13'd4196, win: 16'd0}, "ack_overrun");

    // Half an MSS of reads must not open the window
    app_rd_ptr = 13'd612;
    quiet(10, "sws_no_ack");
    chk("sws_adv_win", 32'(adv_win), 32'd0);
    app_rd_ptr = 13'd1124;
    wait_ack('{ptr: 13'd4196, win: 16'd1024}, "ack_winupd");
    chk("winupd_adv_win", 32'(adv_win), 32'd1024);

    do_init(13'd8150);
    chk("init2_rcv_nxt", 32'(rcv_nxt_ptr), 32'd8150);
    chk("init2_adv_win", 32'(adv_win), 32'd4096);
    send_seg('{start_ptr: 13'd8150, len: 13'd100}, 1'b1, "wrap");
    chk("wrap_rcv_nxt", 32'(rcv_nxt_ptr), 32'd58);
    chk("wrap_adv_win", 32'(adv_win), 32'd3996);
`ifndef TCP_RX_DELAYED_ACK_EN
    wait_ack('{ptr: 13'd58, win: 16'd3996}, "ack_wrap");
`endif

    send_seg('{start_ptr: 13'd58, len: 13'd1025}, 1'b0, "over_mss");
    wait_ack('{ptr: 13'd58, win: 16'd3996}, "ack_over_mss");

    send_seg('{start_ptr: 13'd58, len: 13'd200}, 1'b1, "lone");
    n_cyc = 0;
    while (ack_req_val !== 1'b1 && n_cyc < 2100) begin
      @(posedge clk);
      #1;
      n_cyc++;
    end
`ifdef TCP_RX_DELAYED_ACK_EN
    chk("timeout_cycles", 32'(n_cyc), 32'd2000);
`else
    chk("lone_cycles", 32'(n_cyc), 32'd0);
`endif
    chk("lone_ack_ptr", 32'(ack_req_ptr), 32'd258);
    chk("lone_ack_win", 32'(ack_req_win), 32'd3796);

    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_send_ack_val", 32'(ack_req_val), 32'd0);
    chk("rst_send_rcv_nxt", 32'(rcv_nxt_ptr), 32'd0);
    chk("rst_send_adv_win", 32'(adv_win), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
